mp_add_ctrl: RTL and testbench
==============================

MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

Interface
REQ-001 Parameter N, default 8: adder word width in bits.
REQ-002 Parameter WORDS, default 4, legal range 2 or more: number of words per operand.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1 bit: operand set a/b/cin is valid.
REQ-006 Port in_ready, output, 1 bit: block accepts a new operand set.
REQ-007 Port a, input, N*WORDS bits: operand A; word k is bits [k*N+N-1 : k*N].
REQ-008 Port b, input, N*WORDS bits: operand B, same word layout as a.
REQ-009 Port cin, input, 1 bit: carry-in to word 0.
REQ-010 Port out_valid, output, 1 bit: sum/cout hold a completed result.
REQ-011 Port out_ready, input, 1 bit: consumer takes the result.
REQ-012 Port sum, output, N*WORDS bits: result of a+b+cin, modulo 2^(N*WORDS).
REQ-013 Port cout, output, 1 bit: carry-out of the top word.
REQ-014 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states, IDLE, ADD and DONE: IDLE goes to ADD on accept, ADD goes to DONE after the last word, DONE goes to IDLE on out_valid && out_ready.
REQ-016 Accept SHALL occur on the edge where in_valid && in_ready; at accept the block latches a, b and cin, sets the carry register to cin and sets the word index to 0.
REQ-017 in_ready SHALL be registered: high only in IDLE, and low from the edge after accept.
REQ-018 In ADD, each cycle SHALL add word[idx] of the latched A and B plus the carry register through one N-bit word adder.
REQ-019 In ADD, each cycle SHALL write the word result into sum word[idx], load the carry register with the word carry-out, and increment idx.
REQ-020 When idx equals WORDS-1 in ADD, the next state SHALL be DONE, cout SHALL take the final carry and out_valid SHALL rise.
REQ-021 out_valid SHALL first be high exactly WORDS edges after the accept edge.
REQ-022 The FSM SHALL perform no back-to-back accepts; throughput is 1 operation per WORDS+2 cycles when out_ready is held 1.
REQ-023 In DONE, sum and cout SHALL hold stable until the handshake completes, whatever out_ready does.
REQ-024 in_valid SHALL be ignored in ADD and DONE, and changes on a/b SHALL not affect an operation in flight.
REQ-025 The word index SHALL be $clog2(WORDS) bits wide; it SHALL never exceed WORDS-1 and SHALL return to 0 on accept.
REQ-026 Arithmetic SHALL be unsigned: {cout,sum} = a+b+cin exactly, and the all-ones + 1 case SHALL wrap to sum 0 with cout 1.
REQ-027 sum content SHALL be undefined for the consumer while out_valid is 0, and the partial words SHALL be visible during ADD.

Reset
REQ-028 While rst_n is low, the block SHALL hold: state IDLE, in_ready 0, out_valid 0, busy 0, sum 0, cout 0, carry 0, idx 0.
REQ-029 in_ready SHALL rise on the first rising clk edge after rst_n is released.
REQ-030 Reset asserted during ADD or DONE SHALL abort the operation immediately; no out_valid pulse SHALL follow it.

Configuration
REQ-031 When macro MP_ADD_OVF_EN is defined, an output ovf (1 bit) SHALL equal the top-word carry into its MSB XOR cout, be valid with out_valid, and reset to 0.
REQ-032 When MP_ADD_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package mp_add_pkg SHALL hold the state enum (IDLE, ADD, DONE) and the default constants N_DEF=8 and WORDS_DEF=4.
REQ-034 Sub-module mp_add_word SHALL be a combinational N-bit ripple full adder with ports a, b, ci, s, co and c_msb, the carry into the MSB, used for ovf.
REQ-035 The block SHALL instantiate exactly one mp_add_word and multiplex it across words.

Verification (N=8, WORDS=4)
REQ-036 a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, out_valid 4 edges after accept.
REQ-037 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1 (full-chain carry wrap).
REQ-038 out_ready held 0 for 10 cycles in DONE while in_valid pulses with new operands -> sum, cout and out_valid stable, in_ready=0, new operands not taken.
REQ-039 rst_n pulsed low while idx=2 in ADD -> outputs at reset values, no out_valid; in_ready=1 one edge after release, and the next operation 0x12345678+0x11111111 gives 0x23456789.
REQ-040 With MP_ADD_OVF_EN: 0x7FFFFFFF+0x00000001 -> ovf=1, cout=0; 0x80000000+0x80000000 -> sum=0, cout=1, ovf=1.
REQ-041 1000 random operand sets with random cin and random out_ready stalls SHALL each match a behavioural a+b+cin model exactly, with no lost or duplicated results.

Source files
------------

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared state encoding and default sizing for the multi-word adder.
`default_nettype none

package mp_add_pkg;
  localparam int N_DEF     = 8;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/mp_add_word.sv
// mp_add_word: combinational N-bit ripple-carry adder; c_msb is the carry into the MSB.
`default_nettype none

module mp_add_word
  import mp_add_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [N:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[N];
  assign c_msb = c[N-1];
endmodule

`default_nettype wire

// File: rtl/mp_add_ctrl.sv
// mp_add_ctrl: word-serial multi-precision adder, one word per cycle through a single adder.
// Optional signed-overflow output ovf is enabled by defining MP_ADD_OVF_EN.
`default_nettype none

module mp_add_ctrl
  import mp_add_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef MP_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state, state_nxt;
  logic [N*WORDS-1:0] a_q, b_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic               accept, last, handshake;
  logic [N-1:0]       w_a, w_b, w_s;
  logic               w_co;
`ifdef MP_ADD_OVF_EN
  logic               w_cmsb;
`endif

  assign accept    = in_valid && in_ready && (state == IDLE);
  assign last      = (state == ADD) && (idx == LAST_IDX);
  assign handshake = out_valid && out_ready;
  assign busy      = (state != IDLE);

  // One shared word adder, steered by the word index.
  assign w_a = a_q[idx*N +: N];
  assign w_b = b_q[idx*N +: N];

  mp_add_word #(.N(N)) u_word (
    .a     (w_a),
    .b     (w_b),
    .ci    (carry),
    .s     (w_s),
    .co    (w_co),
`ifdef MP_ADD_OVF_EN
    .c_msb (w_cmsb)
`else
    .c_msb ()
`endif
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last) state_nxt = DONE;
      DONE:    if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
`ifdef MP_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      // Registered ready: drops on the accept edge, so back-to-back accepts are impossible.
      in_ready <= (state_nxt == IDLE);
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        carry <= cin;
        idx   <= '0;
      end else if (state == ADD) begin
        sum[idx*N +: N] <= w_s;
        carry           <= w_co;
        if (last) begin
          cout      <= w_co;
          out_valid <= 1'b1;
`ifdef MP_ADD_OVF_EN
          ovf       <= w_cmsb ^ w_co;
`endif
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mp_add_ctrl.sv
// tb_mp_add_ctrl: directed vector table, stall/reset sequences and random operands vs a+b+cin.
`default_nettype none

module tb_mp_add_ctrl;
  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, out_valid, out_ready, cout, busy;
`ifdef MP_ADD_OVF_EN
  logic         ovf;
`endif

  int pass_cnt = 0;
  int total    = 0;

  mp_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef MP_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic ovf_model(input logic [W-1:0] av, bv, input logic ci);
    logic [W-1:0] s;
    s = av + bv + W'(ci);
    return (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Accept one operand set, check latency/result, stall 'stall' cycles, then hand off.
  task automatic run_op(input logic [W-1:0] av, bv, input logic ci,
                        input logic [W-1:0] es, input logic ec, input int stall);
    int lat = 0;
    wait_ready();
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    chk("in_ready_low_after_accept", 64'(in_ready), 64'd0);
    chk("busy_after_accept", 64'(busy), 64'd1);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(WORDS));
    chk("sum", 64'(sum), 64'(es));
    chk("cout", 64'(cout), 64'(ec));
`ifdef MP_ADD_OVF_EN
    chk("ovf", 64'(ovf), 64'(ovf_model(av, bv, ci)));
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", {30'd0, out_valid, cout, es}, {30'd1, ec, sum});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_after_done", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rs;
    int           lat;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0101, 1'b0};
    vecs[8] = '{32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 32'hDFD1_0456, 1'b0};
    vecs[9] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h0000_0000, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {59'd0, in_ready, out_valid, busy, cout, |sum}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_first_edge", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, i % 3);

    // Consumer stall with new operands offered: result must hold, nothing accepted.
    wait_ready();
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_latency", 64'(lat), 64'(WORDS));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("stall_outputs", {30'd0, in_ready, out_valid, cout, sum},
          {30'd0, 1'b0, 1'b1, 1'b0, 32'h1010_1010});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release", {62'd0, out_valid, busy}, 64'd0);
    @(posedge clk); #1;
    chk("stall_no_accept", {62'd0, busy, in_ready}, 64'd1);

    // Reset while idx=2 in ADD.
    wait_ready();
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_add_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_state", {59'd0, in_ready, out_valid, busy, cout, |sum}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", {62'd0, in_ready, out_valid}, 64'd2);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      rs = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_op(ra, rb, rc, rs[W-1:0], rs[W], $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

`default_nettype wire
